// File: rtl/fmaa_pkg.sv
// Shared types and width helpers for the FMAA sign-aware divider.
package fmaa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        FIX,
        DONE
    } fmaa_div_state_e;

    // Numerator/quotient width: three BW-wide products plus sign and carry headroom
    function automatic int fmaa_nw(input int bw);
        return 3 * bw + 3;
    endfunction

endpackage

// File: rtl/fmaa_sgn_div_if.sv
// Operand/result handshake bundle for fmaa_sgn_div.
interface fmaa_sgn_div_if
    import fmaa_pkg::*;
#(
    parameter int BW = 54
);
    localparam int NW = fmaa_nw(BW);

    logic              in_valid_i;
    logic              in_ready_o;
    logic [3*BW:0]     res_i;
    logic [3*BW:0]     c_i;
    logic [3*BW:0]     d_i;
    logic [BW-1:0]     b_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [NW-1:0]     quo_o;
    logic [BW-1:0]     rem_o;
    logic              div_zero_o;

    modport slave (
        input  in_valid_i, res_i, c_i, d_i, b_i, out_ready_i,
        output in_ready_o, out_valid_o, quo_o, rem_o, div_zero_o
    );

    modport master (
        output in_valid_i, res_i, c_i, d_i, b_i, out_ready_i,
        input  in_ready_o, out_valid_o, quo_o, rem_o, div_zero_o
    );
endinterface

// File: rtl/fmaa_div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module fmaa_div_step #(
    parameter int BW = 54
) (
    input  logic [BW:0]   pr_i,
    input  logic          dvd_bit_i,
    input  logic [BW-1:0] div_i,
    output logic [BW:0]   pr_o,
    output logic          q_o
);
    logic [BW+1:0] trial;
    logic [BW+1:0] diff;

    // The partial remainder stays below |b|, so the top bits of trial are zero
    // in practice; keeping them in the compare makes the step self-contained.
    always_comb begin
        trial = {pr_i, dvd_bit_i};
        diff  = trial - {2'b00, div_i};
        q_o   = ~diff[BW+1];
        pr_o  = q_o ? diff[BW:0] : trial[BW:0];
    end
endmodule

// File: rtl/fmaa_sgn_div.sv
// Iterative signed divider recovering q = (res + c + d) / b with remainder, one bit per cycle.
module fmaa_sgn_div
    import fmaa_pkg::*;
#(
    parameter int BW = 54
) (
    input  logic           clk_i,
    input  logic           rst_i,
    fmaa_sgn_div_if.slave  bus
);
    localparam int NW = fmaa_nw(BW);
    localparam int RW = 3 * BW + 1;
    localparam int CW = $clog2(NW);

    fmaa_div_state_e state_q, state_d;

    logic [RW-1:0] res_q, c_q, d_q;
    logic [BW-1:0] b_q;
    logic [NW-1:0] dvd_q;
    logic [BW-1:0] bmag_q;
    logic [BW:0]   pr_q;
    logic [CW-1:0] count_q;
    logic          n_neg_q;
    logic          q_neg_q;
    logic [NW-1:0] quo_q;
    logic [BW-1:0] rem_q;
    logic          dz_q;

    logic [NW-1:0] n_w;
    logic [NW-1:0] n_mag;
    logic [BW-1:0] b_mag;
    logic [BW:0]   pr_next;
    logic          q_bit;
    logic          accept;

    assign accept = (state_q == IDLE) && bus.in_valid_i;

    // Sign-extend each term by two bits so the three-way sum is exact
    always_comb begin
        n_w   = {{2{res_q[RW-1]}}, res_q} + {{2{c_q[RW-1]}}, c_q} + {{2{d_q[RW-1]}}, d_q};
        n_mag = n_w[NW-1] ? (~n_w + 1'b1) : n_w;
        b_mag = b_q[BW-1] ? (~b_q + 1'b1) : b_q;
    end

    fmaa_div_step #(.BW(BW)) u_step (
        .pr_i      (pr_q),
        .dvd_bit_i (dvd_q[NW-1]),
        .div_i     (bmag_q),
        .pr_o      (pr_next),
        .q_o       (q_bit)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.in_valid_i)      state_d = LOAD;
            LOAD: state_d = (b_q == '0) ? DONE : CALC;
            CALC: if (count_q == '0)       state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (bus.out_ready_i)     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready_o  = (state_q == IDLE) && !rst_i;
        bus.out_valid_o = (state_q == DONE);
        bus.quo_o       = quo_q;
        bus.rem_o       = rem_q;
        bus.div_zero_o  = dz_q;
    end

    // Quotient bits shift into the low end of the dividend register as its MSBs are consumed
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_q   <= '0;
            c_q     <= '0;
            d_q     <= '0;
            b_q     <= '0;
            dvd_q   <= '0;
            bmag_q  <= '0;
            pr_q    <= '0;
            count_q <= '0;
            n_neg_q <= 1'b0;
            q_neg_q <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        res_q <= bus.res_i;
                        c_q   <= bus.c_i;
                        d_q   <= bus.d_i;
                        b_q   <= bus.b_i;
                    end
                end
                LOAD: begin
                    dvd_q   <= n_mag;
                    bmag_q  <= b_mag;
                    pr_q    <= '0;
                    count_q <= CW'(NW - 1);
                    n_neg_q <= n_w[NW-1];
                    q_neg_q <= n_w[NW-1] ^ b_q[BW-1];
                    if (b_q == '0) begin
                        quo_q <= '1;
                        rem_q <= '0;
                        dz_q  <= 1'b1;
                    end
                end
                CALC: begin
                    pr_q    <= pr_next;
                    dvd_q   <= {dvd_q[NW-2:0], q_bit};
                    count_q <= count_q - 1'b1;
                end
                FIX: begin
                    quo_q <= q_neg_q ? (~dvd_q + 1'b1) : dvd_q;
                    rem_q <= n_neg_q ? (~pr_q[BW-1:0] + 1'b1) : pr_q[BW-1:0];
                    dz_q  <= 1'b0;
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fmaa_sgn_div.sv
// Directed-vector bench for fmaa_sgn_div at BW=8 (NW=27, latency 29 edges).
module tb_fmaa_sgn_div;
    localparam int BW  = 8;
    localparam int NW  = 3 * BW + 3;
    localparam int LAT = NW + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fmaa_sgn_div_if #(.BW(BW)) bus ();

    fmaa_sgn_div #(.BW(BW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        int     res;
        int     c;
        int     d;
        int     b;
        longint quo;
        longint rem;
        logic   dz;
        int     lat;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_op(input int res, input int c, input int d, input int b,
                         output longint q, output longint r, output logic dz, output int lat);
        int w;
        @(negedge clk);
        bus.res_i      = 25'(res);
        bus.c_i        = 25'(c);
        bus.d_i        = 25'(d);
        bus.b_i        = 8'(b);
        bus.in_valid_i = 1'b1;
        w = 0;
        while (!bus.in_ready_o && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        bus.res_i      = ~bus.res_i;
        bus.c_i        = ~bus.c_i;
        bus.d_i        = ~bus.d_i;
        bus.b_i        = ~bus.b_i;
        lat = 0;
        while (!bus.out_valid_o && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        q  = $signed(bus.quo_o);
        r  = $signed(bus.rem_o);
        dz = bus.div_zero_o;
    endtask

    task automatic handshake();
        @(negedge clk);
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b0;
    endtask

    vec_t   vecs[11];
    longint q, r, q_hold, r_hold;
    logic   dz;
    int     lat;
    int     seen;

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vecs[0]  = '{100, 20, -3, 10, 11, 7, 1'b0, LAT};
        vecs[1]  = '{-100, 0, -17, 10, -11, -7, 1'b0, LAT};
        vecs[2]  = '{117, 0, 0, -10, -11, 7, 1'b0, LAT};
        vecs[3]  = '{-117, 0, 0, -10, 11, -7, 1'b0, LAT};
        vecs[4]  = '{-16777216, -16777216, -16777216, -128, 393216, 0, 1'b0, LAT};
        vecs[5]  = '{16777215, 16777215, 16777215, -128, -393215, 125, 1'b0, LAT};
        vecs[6]  = '{1234, -77, 9, 0, -1, 0, 1'b1, 1};
        vecs[7]  = '{5, 0, 0, 7, 0, 5, 1'b0, LAT};
        vecs[8]  = '{127, 0, 0, -128, 0, 127, 1'b0, LAT};
        vecs[9]  = '{-1000, 0, 0, 1, -1000, 0, 1'b0, LAT};
        vecs[10] = '{-129, 0, 0, -128, 1, -1, 1'b0, LAT};

        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.res_i = '0; bus.c_i = '0; bus.d_i = '0; bus.b_i = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", longint'(bus.in_ready_o), 0);
        chk("rst_out_valid", longint'(bus.out_valid_o), 0);
        chk("rst_quo", longint'(bus.quo_o), 0);
        chk("rst_rem", longint'(bus.rem_o), 0);
        chk("rst_div_zero", longint'(bus.div_zero_o), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", longint'(bus.in_ready_o), 1);

        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].res, vecs[i].c, vecs[i].d, vecs[i].b, q, r, dz, lat);
            $display("vec %0d: res=%0d c=%0d d=%0d b=%0d -> quo=%0d rem=%0d dz=%0d lat=%0d",
                     i, vecs[i].res, vecs[i].c, vecs[i].d, vecs[i].b, q, r, dz, lat);
            chk($sformatf("vec%0d_quo", i), q, vecs[i].quo);
            chk($sformatf("vec%0d_rem", i), r, vecs[i].rem);
            chk($sformatf("vec%0d_dz", i), longint'(dz), longint'(vecs[i].dz));
            chk($sformatf("vec%0d_lat", i), longint'(lat), longint'(vecs[i].lat));
            handshake();
            chk($sformatf("vec%0d_valid_drop", i), longint'(bus.out_valid_o), 0);
        end

        // Backpressure: DONE held with in_valid asserted and operands churning
        do_op(100, 20, -3, 10, q_hold, r_hold, dz, lat);
        $display("bp op: quo=%0d rem=%0d lat=%0d", q_hold, r_hold, lat);
        chk("bp_quo", q_hold, 11);
        chk("bp_rem", r_hold, 7);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.in_valid_i = 1'b1;
            bus.res_i = 25'($urandom);
            bus.c_i   = 25'($urandom);
            bus.d_i   = 25'($urandom);
            bus.b_i   = 8'($urandom);
            @(posedge clk);
            #1;
            $display("bp cycle %0d: out_valid=%0d in_ready=%0d quo=%0d rem=%0d",
                     k, bus.out_valid_o, bus.in_ready_o, $signed(bus.quo_o), $signed(bus.rem_o));
            chk("bp_out_valid", longint'(bus.out_valid_o), 1);
            chk("bp_in_ready", longint'(bus.in_ready_o), 0);
            chk("bp_quo_stable", longint'($signed(bus.quo_o)), 11);
            chk("bp_rem_stable", longint'($signed(bus.rem_o)), 7);
        end
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        handshake();
        chk("bp_valid_drop", longint'(bus.out_valid_o), 0);
        do_op(-117, 0, 0, -10, q, r, dz, lat);
        $display("post-bp op: quo=%0d rem=%0d lat=%0d", q, r, lat);
        chk("post_bp_quo", q, 11);
        chk("post_bp_rem", r, -7);
        chk("post_bp_lat", longint'(lat), LAT);
        handshake();

        // Reset during the fifth CALC iteration (E6)
        @(negedge clk);
        bus.res_i = 25'(50); bus.c_i = 25'(0); bus.d_i = 25'(0); bus.b_i = 8'(3);
        bus.in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready_low", longint'(bus.in_ready_o), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        $display("mid-reset release: out_valid=%0d in_ready=%0d", bus.out_valid_o, bus.in_ready_o);
        chk("midrst_out_valid", longint'(bus.out_valid_o), 0);
        chk("midrst_in_ready", longint'(bus.in_ready_o), 1);
        chk("midrst_quo", longint'(bus.quo_o), 0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid_o) seen++;
        end
        chk("midrst_no_stale", longint'(seen), 0);
        do_op(50, 0, 0, 3, q, r, dz, lat);
        $display("post-reset op: quo=%0d rem=%0d lat=%0d", q, r, lat);
        chk("post_rst_quo", q, 16);
        chk("post_rst_rem", r, 2);
        chk("post_rst_lat", longint'(lat), LAT);
        handshake();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fmaa_sgn_div.md
# fmaa_sgn_div

Iterative signed divider that inverts the fused multiply-subtract-subtract datapath. It recovers the multiplicand from a result word and its two subtrahends: it forms n = res + c + d exactly, then computes q = n / b (truncating) and r = n − q·b. It sits beside the FMAA datapath as a check/recovery unit, with valid/ready handshakes on both sides and one quotient bit per cycle.

## Interface
- BW, default 54: multiplier operand width; res/c/d are 3·BW+1 bits.
- NW, derived 3·BW+3, not overridable: numerator/quotient width.
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- in_valid_i  in  1  operand set valid
- in_ready_o  out  1  block can accept operands
- res_i  in  3·BW+1  signed result word
- c_i  in  3·BW+1  signed subtrahend
- d_i  in  3·BW+1  signed subtrahend
- b_i  in  BW  signed divisor (multiplier operand)
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- quo_o  out  NW  signed quotient
- rem_o  out  BW  signed remainder
- div_zero_o  out  1  b_i was zero

## Operation
- Accept on rising edge with in_valid_i && in_ready_o. Operands are captured, and later input changes are ignored.
- Numerator: n = res + c + d, sign-extended to NW bits, exact. |n| ≤ 3·2^(3BW) < 2^(NW−1), so quotient overflow is impossible and no flag is needed.
- Result semantics:
  - q truncates toward zero.
  - sign(r) = sign(n), |r| < |b|.
  - r always fits in BW bits.
- Algorithm: unsigned restoring division on |n| (NW bits) and |b| (BW bits).
  - Partial remainder is BW+1 bits.
  - Quotient bits shift into the dividend register.
  - Signs are applied in FIX.
- FSM states IDLE, LOAD, CALC, FIX, DONE:
  - IDLE: in_ready_o=1. Go to LOAD on accept.
  - LOAD: form n, take magnitudes, record signs, count=NW−1. If b==0, go to DONE with quo_o = all ones, rem_o=0, div_zero_o=1. Otherwise go to CALC.
  - CALC: one iteration per cycle. Go to FIX when count==0, else decrement.
  - FIX: negate q if sign(n)≠sign(b), negate r if n<0, register outputs, then go to DONE.
  - DONE: out_valid_o=1, outputs held stable. Go to IDLE on out_ready_i.
- in_ready_o is 1 only in IDLE, so there is no input/output overlap. The accept after DONE occurs at the earliest one cycle after the output handshake.
- Reset values: state IDLE; out_valid_o=0, quo_o=0, rem_o=0, div_zero_o=0. in_ready_o is forced 0 while rst_i=1.
- Reset mid-operation aborts the operation and no result is emitted.

## Timing
- Accepting edge is E0. LOAD is evaluated at E1. CALC iterates at E2..E(NW+1). FIX is at E(NW+2).
- out_valid_o is high from after E(NW+2): latency NW+2 edges (167 at BW=54).
- Divide by zero: out_valid_o is high after E1.
- Throughput: one operation per NW+4 cycles minimum. Backpressure extends DONE indefinitely.
- in_ready_o is high the cycle after rst_i deasserts.
- All outputs are registered. quo_o, rem_o and div_zero_o change only on the transition into DONE or on reset.

## Structure
- Package fmaa_pkg:
  - state enum fmaa_div_state_e (IDLE, LOAD, CALC, FIX, DONE)
  - function fmaa_nw(bw) returning 3·bw+3
- Sub-module fmaa_div_step:
  - combinational single restoring iteration
  - inputs: partial remainder, next dividend bit, |b|
  - outputs: next partial remainder and quotient bit
  - the FSM/counter/shift registers stay in the top.

## Test plan
- BW=8, res=100, c=20, d=−3, b=10 -> quo=11, rem=7, div_zero=0. out_valid rises after edge 29 counted from the accept edge.
- BW=8, sign cases:
  - res=−100, c=0, d=−17, b=10 -> quo=−11, rem=−7
  - n=117, b=−10 -> quo=−11, rem=7
- BW=8 extremes:
  - res=c=d=−2^24, b=−128 -> quo=393216, rem=0
  - res=c=d=2^24−1, b=−128 -> quo=−393215, rem=125
- b=0, any n -> after E1: quo all ones, rem=0, div_zero=1. The next operation clears div_zero.
- Backpressure: hold out_ready_i=0 for 10 cycles in DONE, with in_valid_i=1 and changing operands.
  - outputs stay stable, in_ready_o=0, nothing is accepted
  - after the handshake the next operation is correct
- Reset asserted during CALC iteration 5 -> out_valid_o=0, in_ready_o=1 the cycle after release, no stale result. A following operation produces the correct result at the full latency.
